// File: rtl/ysyx_22041211_nextpc_bpu_if.sv
// Fetch/resolve bus of the next-PC unit.
// Fetch side: the stall input and the current PC with its prediction.
// Resolve side: branch resolution from execute, plus the flush/redirect
// reply sent back to the pipeline.
interface ysyx_22041211_nextpc_bpu_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            resolve_valid;
  logic [1:0]      resolve_kind;
  logic [XLEN-1:0] resolve_pc;
  logic            resolve_taken;
  logic [XLEN-1:0] resolve_target;
  logic            resolve_pred_taken;
  logic [XLEN-1:0] resolve_pred_target;
  logic            flush;
  logic [1:0]      redirect_src;

  // Pipeline side: drives stall and resolutions, consumes PC, prediction and flush.
  modport master (
    output stall, resolve_valid, resolve_kind, resolve_pc, resolve_taken,
           resolve_target, resolve_pred_taken, resolve_pred_target,
    input  pc, pred_taken, pred_target, flush, redirect_src
  );

  // Next-PC unit side.
  modport slave (
    input  stall, resolve_valid, resolve_kind, resolve_pc, resolve_taken,
           resolve_target, resolve_pred_taken, resolve_pred_target,
    output pc, pred_taken, pred_target, flush, redirect_src
  );
endinterface

// File: rtl/ysyx_22041211_nextpc_bpu.sv
// Next-PC unit: holds the fetch PC in a register. A direct-mapped BTB with
// 2-bit saturating counters predicts the next fetch address. When execute
// reports a mispredict, the unit flushes younger instructions and loads the
// correct PC into the register.
module ysyx_22041211_nextpc_bpu #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
  parameter int              BTB_ENTRIES = 16
) (
  input logic                          clk,
  input logic                          rst_n,
  ysyx_22041211_nextpc_bpu_if.slave    bus
);
  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam int TGTW = XLEN - 2;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'b00,
    KIND_BRANCH = 2'b01,
    KIND_JAL    = 2'b10,
    KIND_JALR   = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_BJ   = 2'b01,
    RD_JALR = 2'b10
  } redirect_e;

  logic [XLEN-1:0] pc_q;

  logic            btb_valid  [BTB_ENTRIES];
  logic [1:0]      btb_ctr    [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
  logic [TGTW-1:0] btb_target [BTB_ENTRIES];

  // ---------------- Lookup on the current fetch PC ----------------
  logic [IDX-1:0]  l_idx;
  logic            l_hit;
  logic            l_taken;
  logic [XLEN-1:0] pc_plus4;

  assign l_idx    = pc_q[IDX+1:2];
  assign l_hit    = btb_valid[l_idx] && (btb_tag[l_idx] == pc_q[XLEN-1:IDX+2]);
  assign l_taken  = l_hit && btb_ctr[l_idx][1];
  assign pc_plus4 = pc_q + XLEN'(4);

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = rst_n & l_taken;
  assign bus.pred_target = l_taken ? {btb_target[l_idx], 2'b00} : pc_plus4;

  // ---------------- Resolution from execute ----------------
  kind_e           r_kind;
  logic            actual_taken;
  logic [XLEN-1:0] correct_next;
  logic            mispredict;
  logic            upd_en;
  logic [IDX-1:0]  r_idx;
  logic [TAGW-1:0] r_tag;
  logic            r_hit;

  assign r_kind = kind_e'(bus.resolve_kind);

  // Decode the real outcome of the resolved instruction.
  always_comb begin
    // NOTE: a default at the top of every always_comb keeps each path
    // assigned, so no latch is inferred.
    actual_taken = 1'b0;
    case (r_kind)
      KIND_BRANCH:       actual_taken = bus.resolve_taken;
      KIND_JAL, KIND_JALR: actual_taken = 1'b1;
      default:           actual_taken = 1'b0;
    endcase
  end

  assign correct_next = actual_taken ? {bus.resolve_target[XLEN-1:2], 2'b00}
                                     : bus.resolve_pc + XLEN'(4);
  assign mispredict   = bus.resolve_valid &
                        ((actual_taken != bus.resolve_pred_taken) |
                         (actual_taken & (correct_next != bus.resolve_pred_target)));
  assign upd_en       = bus.resolve_valid && (r_kind != KIND_NONE);
  assign r_idx        = bus.resolve_pc[IDX+1:2];
  assign r_tag        = bus.resolve_pc[XLEN-1:IDX+2];
  assign r_hit        = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);

  // The target is word-aligned, so its two low bits never reach a register.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^bus.resolve_target[1:0];

  // Mealy flush/redirect reply, held quiet while reset is asserted.
  always_comb begin
    bus.flush        = 1'b0;
    bus.redirect_src = RD_NONE;
    if (rst_n && mispredict) begin
      bus.flush        = 1'b1;
      bus.redirect_src = (r_kind == KIND_JALR) ? RD_JALR : RD_BJ;
    end
  end

  // Fetch PC register: a redirect beats stall, stall beats prediction.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples pre-edge values.
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (mispredict) begin
      pc_q <= correct_next;
    end else if (!bus.stall) begin
      pc_q <= bus.pred_target;
    end
  end

  // BTB valid bits and counters: reset to invalid/weakly-not-taken, then trained on resolves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= 2'b01;
      end
    end else if (upd_en) begin
      if (r_hit) begin
        if (actual_taken) begin
          btb_ctr[r_idx] <= (btb_ctr[r_idx] == 2'b11) ? 2'b11 : btb_ctr[r_idx] + 2'd1;
        end else begin
          btb_ctr[r_idx] <= (btb_ctr[r_idx] == 2'b00) ? 2'b00 : btb_ctr[r_idx] - 2'd1;
        end
      end else if (actual_taken) begin
        btb_valid[r_idx] <= 1'b1;
        btb_ctr[r_idx]   <= 2'b10;
      end
    end
  end

  // BTB tag/target payload: written on every taken resolve.
  always_ff @(posedge clk) begin
    // NOTE: the payload arrays have no reset. Their contents only matter
    // once valid is set, so they can map onto plain RAM.
    if (upd_en && actual_taken) begin
      btb_tag[r_idx]    <= r_tag;
      btb_target[r_idx] <= bus.resolve_target[XLEN-1:2];
    end
  end
endmodule
